pll_reconfig_sequencer: RTL and testbench



---
 rtl/pll_reconfig_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_pll_reconfig_sequencer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: runs one PLL reconfiguration (mode, N/M/C, start, status poll,
// lock wait) through the reconfig controller's Avalon-MM slave. Optional macro: PLL_RECONFIG_SEQ_READBACK_EN.
module pll_reconfig_sequencer #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c,
  input  logic [4:0]  cfg_c_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [5:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        pll_locked
);

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_POLL = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
  localparam logic [1:0] ERR_READBACK = 2'd3;
`endif

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    MODE  = 4'd1,
    WR_N  = 4'd2,
    WR_M  = 4'd3,
    WR_C  = 4'd4,
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
    RB_N  = 4'd5,
    RB_M  = 4'd6,
`endif
    START = 4'd7,
    POLL  = 4'd8,
    LOCK  = 4'd9,
    DONE  = 4'd10,
    ERR   = 4'd11
  } state_t;

  function automatic logic [31:0] counter_word(input logic [17:0] value);
    return {14'b0, value};
  endfunction

  function automatic logic [31:0] c_word(input logic [4:0] sel, input logic [17:0] value);
    return {9'b0, sel, value};
  endfunction

  state_t          state_r;
  logic [17:0]     n_r;
  logic [17:0]     m_r;
  logic [17:0]     c_r;
  logic [4:0]      c_sel_r;
  logic [PW-1:0]   poll_cnt_r;
  logic [LW-1:0]   lock_cnt_r;
  logic            lock_meta_r;
  logic            lock_sync_r;
  logic            unused_rd_s;

  // Only a few readdata bits carry meaning for this controller.
  assign unused_rd_s = ^avm_readdata;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Sequencer FSM with registered Avalon strobes and status outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r       <= IDLE;
      cfg_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      avm_address   <= 6'h00;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0000_0000;
      n_r           <= 18'h0_0000;
      m_r           <= 18'h0_0000;
      c_r           <= 18'h0_0000;
      c_sel_r       <= 5'd0;
      poll_cnt_r    <= '0;
      lock_cnt_r    <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            n_r           <= cfg_n;
            m_r           <= cfg_m;
            c_r           <= cfg_c;
            c_sel_r       <= cfg_c_sel;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
            cfg_ready     <= 1'b0;
            busy          <= 1'b1;
            avm_write     <= 1'b1;
            avm_address   <= ADDR_MODE;
            avm_writedata <= 32'h0000_0001;
            state_r       <= MODE;
          end
        end
        MODE: begin
          if (!avm_waitrequest) begin
            avm_address   <= ADDR_N;
            avm_writedata <= counter_word(n_r);
            state_r       <= WR_N;
          end
        end
        WR_N: begin
          if (!avm_waitrequest) begin
            avm_address   <= ADDR_M;
            avm_writedata <= counter_word(m_r);
            state_r       <= WR_M;
          end
        end
        WR_M: begin
          if (!avm_waitrequest) begin
            avm_address   <= ADDR_C;
            avm_writedata <= c_word(c_sel_r, c_r);
            state_r       <= WR_C;
          end
        end
        WR_C: begin
          if (!avm_waitrequest) begin
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
            avm_write     <= 1'b0;
            avm_read      <= 1'b1;
            avm_address   <= ADDR_N;
            avm_writedata <= 32'h0000_0000;
            state_r       <= RB_N;
`else
            avm_address   <= ADDR_START;
            avm_writedata <= 32'h0000_0001;
            state_r       <= START;
`endif
          end
        end
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
        RB_N: begin
          if (!avm_waitrequest) begin
            if (avm_readdata[17:0] != n_r) begin
              avm_read    <= 1'b0;
              avm_address <= 6'h00;
              error       <= 1'b1;
              err_code    <= ERR_READBACK;
              state_r     <= ERR;
            end else begin
              avm_address <= ADDR_M;
              state_r     <= RB_M;
            end
          end
        end
        RB_M: begin
          if (!avm_waitrequest) begin
            avm_read    <= 1'b0;
            if (avm_readdata[17:0] != m_r) begin
              avm_address <= 6'h00;
              error       <= 1'b1;
              err_code    <= ERR_READBACK;
              state_r     <= ERR;
            end else begin
              avm_write     <= 1'b1;
              avm_address   <= ADDR_START;
              avm_writedata <= 32'h0000_0001;
              state_r       <= START;
            end
          end
        end
`endif
        START: begin
          if (!avm_waitrequest) begin
            avm_write     <= 1'b0;
            avm_read      <= 1'b1;
            avm_address   <= ADDR_STATUS;
            avm_writedata <= 32'h0000_0000;
            poll_cnt_r    <= '0;
            state_r       <= POLL;
          end
        end
        POLL: begin
          if (!avm_waitrequest) begin
            if (avm_readdata[0]) begin
              avm_read    <= 1'b0;
              avm_address <= 6'h00;
              lock_cnt_r  <= '0;
              state_r     <= LOCK;
            end else if (poll_cnt_r == POLL_LAST) begin
              avm_read    <= 1'b0;
              avm_address <= 6'h00;
              error       <= 1'b1;
              err_code    <= ERR_POLL;
              state_r     <= ERR;
            end else begin
              poll_cnt_r  <= poll_cnt_r + PW'(1);
            end
          end
        end
        LOCK: begin
          // Trust lock only from the second LOCK cycle, once it was sampled after the start write.
          if (lock_sync_r && (lock_cnt_r != '0)) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else if (lock_cnt_r == LOCK_LAST) begin
            error    <= 1'b1;
            err_code <= ERR_LOCK;
            state_r  <= ERR;
          end else begin
            lock_cnt_r <= lock_cnt_r + LW'(1);
          end
        end
        DONE: begin
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state_r   <= IDLE;
        end
        ERR: begin
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          avm_read      <= 1'b0;
          avm_write     <= 1'b0;
          avm_address   <= 6'h00;
          avm_writedata <= 32'h0000_0000;
          busy          <= 1'b0;
          cfg_ready     <= 1'b1;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench for pll_reconfig_sequencer: an Avalon slave model with wait-state
// insertion logs completed transfers, each test task compares them against pushed expectations.
`timescale 1ns/1ps
module tb_pll_reconfig_sequencer;

  localparam int POLL_TO = 8;
  localparam int LOCK_TO = 16;
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
  localparam int RB_EXTRA = 2;
`else
  localparam int RB_EXTRA = 0;
`endif

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } xfer_t;

  localparam logic [17:0] TN [3] = '{18'h00101, 18'h3FFFF, 18'h00000};
  localparam logic [17:0] TM [3] = '{18'h00404, 18'h00001, 18'h3FFFF};
  localparam logic [17:0] TC [3] = '{18'h00202, 18'h2AAAA, 18'h15555};
  localparam logic [4:0]  TS [3] = '{5'd2, 5'd31, 5'd0};

  logic        clk_clk;
  logic        reset_reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [17:0] cfg_n;
  logic [17:0] cfg_m;
  logic [17:0] cfg_c;
  logic [4:0]  cfg_c_sel;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [5:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        pll_locked;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  xfer_t stall_q[$];
  xfer_t mon_x;

  logic        status_done;
  logic [31:0] rb_corrupt;
  logic [5:0]  wait_addr;
  int          wait_total;
  int          stall_cnt = 0;
  logic [31:0] slv_n = 32'h0;
  logic [31:0] slv_m = 32'h0;

  pll_reconfig_sequencer #(.POLL_TIMEOUT(POLL_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c(cfg_c), .cfg_c_sel(cfg_c_sel),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .pll_locked(pll_locked)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Slave model: wait states on writes to wait_addr, N/M storage for readback
  assign avm_waitrequest = avm_write && (avm_address == wait_addr) && (stall_cnt < wait_total);

  always_comb begin
    case (avm_address)
      6'h01:   avm_readdata = {31'b0, status_done};
      6'h03:   avm_readdata = slv_n ^ rb_corrupt;
      6'h04:   avm_readdata = slv_m;
      default: avm_readdata = 32'h0;
    endcase
  end

  always @(posedge clk_clk) begin
    if (avm_write && (avm_address == wait_addr)) begin
      if (stall_cnt < wait_total) stall_cnt <= stall_cnt + 1;
    end else begin
      stall_cnt <= 0;
    end
    if (avm_write && !avm_waitrequest && avm_address == 6'h03) slv_n <= avm_writedata;
    if (avm_write && !avm_waitrequest && avm_address == 6'h04) slv_m <= avm_writedata;
  end

  // Bus monitor: stalled and completed transfers, sampled mid-cycle
  always @(negedge clk_clk) begin
    if (reset_reset_n && (avm_read || avm_write)) begin
      mon_x.wr   = avm_write;
      mon_x.addr = avm_address;
      mon_x.data = avm_write ? avm_writedata : 32'h0;
      if (avm_waitrequest) stall_q.push_back(mon_x);
      else obs_q.push_back(mon_x);
      n_checks = n_checks + 1;
      if (avm_read && avm_write) begin
        n_fail = n_fail + 1;
        $display("FAIL rd_wr_exclusive: read=%0b write=%0b, required not both high", avm_read, avm_write);
      end
    end
  end

  task automatic issue(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c,
                       input logic [4:0] sel, output int acc, output logic to);
    int k;
    k = 0;
    while (!cfg_ready && k < 50) begin
      @(negedge clk_clk);
      k++;
    end
    to  = !cfg_ready;
    acc = cyc;
    cfg_n = n; cfg_m = m; cfg_c = c; cfg_c_sel = sel;
    cfg_valid = 1'b1;
    exp_q.push_back({1'b1, 6'h00, 32'h00000001});
    exp_q.push_back({1'b1, 6'h03, 14'b0, n});
    exp_q.push_back({1'b1, 6'h04, 14'b0, m});
    exp_q.push_back({1'b1, 6'h05, 9'b0, sel, c});
    @(negedge clk_clk);
    cfg_valid = 1'b0;
    cfg_n = ~n; cfg_m = ~m; cfg_c = ~c; cfg_c_sel = ~sel;
  endtask

  task automatic push_tail(input logic [17:0] n, input logic [17:0] m, input int reads);
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
    exp_q.push_back({1'b0, 6'h03, 32'h0});
    exp_q.push_back({1'b0, 6'h04, 32'h0});
`endif
    exp_q.push_back({1'b1, 6'h02, 32'h00000001});
    for (int i = 0; i < reads; i++) exp_q.push_back({1'b0, 6'h01, 32'h0});
  endtask

  task automatic wait_end(output int fin, output logic saw_done, output logic saw_err, output logic to);
    int k;
    k = 0;
    while (!done && !error && k < 200) begin
      @(negedge clk_clk);
      k++;
    end
    saw_done = done;
    saw_err  = error;
    fin      = cyc;
    to       = !(done || error);
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    n_checks++;
    if ({cfg_ready, busy, done, error, err_code, avm_read, avm_write} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 10000000", {cfg_ready, busy, done, error, err_code, avm_read, avm_write});
    end
    n_checks++;
    if ({avm_address, avm_writedata} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%0h data=%0h, required 0/0", avm_address, avm_writedata);
    end
    reset_reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%0b busy=%0b, required 1/0", cfg_ready, busy);
    end
  endtask

  task automatic test_nominal();
    int acc, fin;
    logic sd, se, to;
    xfer_t e, o;
    for (int t = 0; t < 3; t++) begin
      exp_q.delete(); obs_q.delete(); stall_q.delete();
      issue(TN[t], TM[t], TC[t], TS[t], acc, to);
      push_tail(TN[t], TM[t], 1);
      n_checks++;
      if (to || busy !== 1'b1 || cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL nominal_accept[%0d]: got to=%0b busy=%0b ready=%0b, required 0/1/0", t, to, busy, cfg_ready);
      end
      wait_end(fin, sd, se, to);
      n_checks++;
      if (!sd || se || (fin - acc) != 9 + RB_EXTRA) begin
        n_fail++;
        $display("FAIL nominal_latency[%0d]: got done=%0b err=%0b lat=%0d, required 1/0/%0d", t, sd, se, fin - acc, 9 + RB_EXTRA);
      end
      @(negedge clk_clk);
      n_checks++;
      if (done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL nominal_after[%0d]: got done=%0b ready=%0b busy=%0b, required 0/1/0", t, done, cfg_ready, busy);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL nominal_count[%0d]: got %0d transfers, required %0d", t, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL nominal_xfer[%0d]: got wr=%0b addr=%0h data=%0h, required wr=%0b addr=%0h data=%0h", t, o.wr, o.addr, o.data, e.wr, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_waitrequest();
    int acc, fin;
    logic sd, se, to;
    xfer_t e, o;
    exp_q.delete(); obs_q.delete(); stall_q.delete();
    wait_addr = 6'h04; wait_total = 3;
    issue(18'h00101, 18'h00404, 18'h00202, 5'd2, acc, to);
    push_tail(18'h00101, 18'h00404, 1);
    wait_end(fin, sd, se, to);
    n_checks++;
    if (to || !sd || (fin - acc) != 12 + RB_EXTRA) begin
      n_fail++;
      $display("FAIL wait_latency: got done=%0b lat=%0d, required 1/%0d", sd, fin - acc, 12 + RB_EXTRA);
    end
    n_checks++;
    if (stall_q.size() != 3) begin
      n_fail++;
      $display("FAIL wait_stalls: got %0d stalled cycles, required 3", stall_q.size());
    end
    while (stall_q.size() > 0) begin
      o = stall_q.pop_front();
      n_checks++;
      if (o !== {1'b1, 6'h04, 32'h00000404}) begin
        n_fail++;
        $display("FAIL wait_stable: got wr=%0b addr=%0h data=%0h, required 1/4/404", o.wr, o.addr, o.data);
      end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wait_count: got %0d transfers, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wait_xfer: got wr=%0b addr=%0h data=%0h, required wr=%0b addr=%0h data=%0h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    wait_total = 0; wait_addr = 6'h3F;
    @(negedge clk_clk);
  endtask

  task automatic test_poll_timeout();
    int acc, fin;
    logic sd, se, to;
    xfer_t e, o;
    exp_q.delete(); obs_q.delete(); stall_q.delete();
    status_done = 1'b0;
    issue(18'h00011, 18'h00022, 18'h00033, 5'd4, acc, to);
    push_tail(18'h00011, 18'h00022, POLL_TO);
    wait_end(fin, sd, se, to);
    n_checks++;
    if (to || sd || !se || err_code !== 2'd1 || (fin - acc) != 14 + RB_EXTRA) begin
      n_fail++;
      $display("FAIL poll_timeout: got done=%0b err=%0b code=%0d lat=%0d, required 0/1/1/%0d", sd, se, err_code, fin - acc, 14 + RB_EXTRA);
    end
    @(negedge clk_clk);
    n_checks++;
    if (cfg_ready !== 1'b1 || error !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL poll_after: got ready=%0b error=%0b done=%0b, required 1/1/0", cfg_ready, error, done);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL poll_count: got %0d transfers, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL poll_xfer: got wr=%0b addr=%0h data=%0h, required wr=%0b addr=%0h data=%0h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    status_done = 1'b1;
  endtask

  task automatic test_lock_timeout();
    int acc, fin;
    logic sd, se, to;
    xfer_t e, o;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk_clk);
    exp_q.delete(); obs_q.delete(); stall_q.delete();
    issue(18'h00101, 18'h00404, 18'h00202, 5'd2, acc, to);
    push_tail(18'h00101, 18'h00404, 1);
    wait_end(fin, sd, se, to);
    n_checks++;
    if (to || sd || !se || err_code !== 2'd2 || (fin - acc) != 23 + RB_EXTRA) begin
      n_fail++;
      $display("FAIL lock_timeout: got done=%0b err=%0b code=%0d lat=%0d, required 0/1/2/%0d", sd, se, err_code, fin - acc, 23 + RB_EXTRA);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL lock_count: got %0d transfers, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL lock_xfer: got wr=%0b addr=%0h data=%0h, required wr=%0b addr=%0h data=%0h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    pll_locked = 1'b1;
    repeat (3) @(negedge clk_clk);
    n_checks++;
    if (error !== 1'b1 || err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL lock_sticky: got error=%0b code=%0d, required 1/2", error, err_code);
    end
    exp_q.delete(); obs_q.delete();
    issue(18'h3FFFF, 18'h00001, 18'h2AAAA, 5'd31, acc, to);
    push_tail(18'h3FFFF, 18'h00001, 1);
    n_checks++;
    if (to || error !== 1'b0 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_clear: got error=%0b code=%0d, required 0/0", error, err_code);
    end
    wait_end(fin, sd, se, to);
    n_checks++;
    if (to || !sd || se || (fin - acc) != 9 + RB_EXTRA) begin
      n_fail++;
      $display("FAIL lock_recover: got done=%0b err=%0b lat=%0d, required 1/0/%0d", sd, se, fin - acc, 9 + RB_EXTRA);
    end
    @(negedge clk_clk);
  endtask

  task automatic test_reset_mid();
    int acc, fin, k;
    logic sd, se, to;
    xfer_t e, o;
    exp_q.delete(); obs_q.delete(); stall_q.delete();
    issue(18'h00123, 18'h00456, 18'h00789, 5'd7, acc, to);
    k = 0;
    while (!(avm_write && avm_address == 6'h04) && k < 20) begin
      @(negedge clk_clk);
      k++;
    end
    n_checks++;
    if (!(avm_write && avm_address == 6'h04)) begin
      n_fail++;
      $display("FAIL rstmid_reach: got write=%0b addr=%0h, required 1/4", avm_write, avm_address);
    end
    reset_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_ready, busy, done, error, err_code, avm_read, avm_write} !== 8'b1000_0000 ||
        {avm_address, avm_writedata} !== 38'h0) begin
      n_fail++;
      $display("FAIL rstmid_values: got ctrl=%b addr=%0h data=%0h, required 10000000/0/0",
               {cfg_ready, busy, done, error, err_code, avm_read, avm_write}, avm_address, avm_writedata);
    end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    exp_q.delete(); obs_q.delete(); stall_q.delete();
    issue(18'h00101, 18'h00404, 18'h00202, 5'd2, acc, to);
    push_tail(18'h00101, 18'h00404, 1);
    wait_end(fin, sd, se, to);
    n_checks++;
    if (to || !sd || se || (fin - acc) != 9 + RB_EXTRA) begin
      n_fail++;
      $display("FAIL rstmid_rerun: got done=%0b err=%0b lat=%0d, required 1/0/%0d", sd, se, fin - acc, 9 + RB_EXTRA);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d transfers, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rstmid_xfer: got wr=%0b addr=%0h data=%0h, required wr=%0b addr=%0h data=%0h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    @(negedge clk_clk);
  endtask

`ifdef PLL_RECONFIG_SEQ_READBACK_EN
  task automatic test_readback();
    int acc, fin;
    logic sd, se, to;
    xfer_t e, o;
    exp_q.delete(); obs_q.delete(); stall_q.delete();
    rb_corrupt = 32'h00000001;
    issue(18'h00101, 18'h00404, 18'h00202, 5'd2, acc, to);
    exp_q.push_back({1'b0, 6'h03, 32'h0});
    wait_end(fin, sd, se, to);
    n_checks++;
    if (to || sd || !se || err_code !== 2'd3 || (fin - acc) != 6) begin
      n_fail++;
      $display("FAIL rb_mismatch: got done=%0b err=%0b code=%0d lat=%0d, required 0/1/3/6", sd, se, err_code, fin - acc);
    end
    repeat (3) @(negedge clk_clk);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rb_count: got %0d transfers, required %0d (no start write)", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rb_xfer: got wr=%0b addr=%0h data=%0h, required wr=%0b addr=%0h data=%0h", o.wr, o.addr, o.data, e.wr, e.addr, e.data);
      end
    end
    rb_corrupt = 32'h0;
  endtask
`endif

  initial begin
    reset_reset_n = 1'b0;
    cfg_valid = 1'b0; cfg_n = 18'h0; cfg_m = 18'h0; cfg_c = 18'h0; cfg_c_sel = 5'd0;
    pll_locked = 1'b1; status_done = 1'b1; rb_corrupt = 32'h0;
    wait_addr = 6'h3F; wait_total = 0;
    test_reset();
    test_nominal();
    test_waitrequest();
    test_poll_timeout();
    test_lock_timeout();
    test_reset_mid();
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
